// File: rtl/instr_mem_bootable.sv
// Bootable dual-read-port instruction memory: a LOAD phase fills words from 0 over a
// valid/ready stream, then RUN serves fetch (I) and data (D) reads. Option: IMEM_PARITY_EN.
module instr_mem_bootable #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int LOAD_WORDS = 256,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h83FFF800
) (
   input  logic                  Clock,
   input  logic                  SysReset,
   input  logic                  En_I,
   input  logic [28:0]           Addr_I,
   input  logic                  En_D,
   input  logic [28:0]           Addr_D,
   output logic [DATA_WIDTH-1:0] Data_I,
   output logic [DATA_WIDTH-1:0] Data_D,
   output logic                  Fault_I,
   input  logic                  Ld_Valid,
   output logic                  Ld_Ready,
   input  logic [DATA_WIDTH-1:0] Ld_Data,
   input  logic                  Ld_Last,
   output logic                  Load_Done,
   output logic                  Parity_Err
);

`ifdef IMEM_PARITY_EN
   localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
   localparam int MEM_WIDTH = DATA_WIDTH;
`endif
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(LOAD_WORDS - 1);

   typedef enum logic {LOAD, RUN} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic [MEM_WIDTH-1:0]    mem [DEPTH];
   logic [MEM_WIDTH-1:0]    wrWord, rdI, rdD;
   logic [DATA_WIDTH-1:0]   dataI_q, dataD_q;
   logic                    faultI_q;
   logic                    ldFire, inRangeI, inRangeD, errI, errD;

   assign ldFire   = Ld_Valid && (state_q == LOAD);
   assign inRangeI = (Addr_I >> ADDR_WIDTH) == 29'd0;
   assign inRangeD = (Addr_D >> ADDR_WIDTH) == 29'd0;
   assign rdI      = mem[Addr_I[ADDR_WIDTH-1:0]];
   assign rdD      = mem[Addr_D[ADDR_WIDTH-1:0]];

`ifdef IMEM_PARITY_EN
   // Even parity: the stored bit makes the XOR of the whole word zero.
   assign wrWord = {^Ld_Data, Ld_Data};
   assign errI   = En_I && inRangeI && (^rdI);
   assign errD   = En_D && inRangeD && (^rdD);
`else
   assign wrWord = Ld_Data;
   assign errI   = 1'b0;
   assign errD   = 1'b0;
`endif

   always_ff @(posedge Clock or negedge SysReset) begin
      if (!SysReset) begin
         state_q <= LOAD;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Ld_Last and the capacity limit share one transition, so no extra word is written.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (ldFire) begin
         ptr_d = ptr_q + 1'b1;
         if (Ld_Last || (ptr_q == LAST_PTR)) state_d = RUN;
      end
   end

   always_comb begin
      Ld_Ready  = (state_q == LOAD);
      Load_Done = (state_q == RUN);
   end

   // Memory contents survive reset, so the write port carries no reset.
   always_ff @(posedge Clock) begin
      if (ldFire) mem[ptr_q] <= wrWord;
   end

   always_ff @(posedge Clock or negedge SysReset) begin
      if (!SysReset) begin
         dataI_q  <= NOP_WORD;
         dataD_q  <= '0;
         faultI_q <= 1'b0;
      end else if (state_q == LOAD) begin
         dataI_q  <= NOP_WORD;
         dataD_q  <= '0;
         faultI_q <= 1'b0;
      end else begin
         if (En_I) begin
            faultI_q <= !inRangeI;
            dataI_q  <= (!inRangeI || errI) ? NOP_WORD : rdI[DATA_WIDTH-1:0];
         end
         if (En_D) dataD_q <= inRangeD ? rdD[DATA_WIDTH-1:0] : '0;
      end
   end

`ifdef IMEM_PARITY_EN
   logic parErr_q;
   always_ff @(posedge Clock or negedge SysReset) begin
      if (!SysReset)                           parErr_q <= 1'b0;
      else if (state_q == LOAD)                parErr_q <= 1'b0;
      else if (errI || errD)                   parErr_q <= 1'b1;
      else if (En_I || En_D)                   parErr_q <= 1'b0;
   end
   assign Parity_Err = parErr_q;
`else
   assign Parity_Err = 1'b0;
`endif

   assign Data_I  = dataI_q;
   assign Data_D  = dataD_q;
   assign Fault_I = faultI_q;

endmodule

// File: doc/instr_mem_bootable.md
Name: instr_mem_bootable

Overview:
Parametrised dual-read-port instruction memory with a built-in boot-load write channel, replacing the fixed 1KB device-specific instruction memory wrapper. After reset, a load FSM accepts program words over a valid/ready stream and writes them sequentially from word 0. It then switches to RUN, where the fetch port (I) and the data-load port (D) read with one-cycle latency. The fetch port returns NOP until the program is loaded and for out-of-range addresses.

Parameters:
ADDR_WIDTH, 8, memory word-address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width
LOAD_WORDS, 256, maximum words accepted before automatic switch to RUN (1..2**ADDR_WIDTH)
NOP_WORD, 32'h83FFF800, word driven on Data_I when no valid instruction is available

Ports:
Clock  in  1  system clock, rising edge
SysReset  in  1  asynchronous, active-low reset
En_I  in  1  fetch-port read enable
Addr_I  in  29  fetch word address
En_D  in  1  data-port read enable
Addr_D  in  29  data word address
Data_I  out  DATA_WIDTH  fetch data, registered
Data_D  out  DATA_WIDTH  data-port data, registered
Fault_I  out  1  fetch address out of range, registered with Data_I
Ld_Valid  in  1  load word valid
Ld_Ready  out  1  load channel ready; high only in LOAD
Ld_Data  in  DATA_WIDTH  load word
Ld_Last  in  1  final word of the program; qualified by Ld_Valid
Load_Done  out  1  high in RUN
Parity_Err  out  1  read parity mismatch (see Optional Feature)

Behaviour:
- Reset (SysReset=0, async): state=LOAD, write pointer=0, Data_I=NOP_WORD, Data_D=0, Fault_I=0, Parity_Err=0, Load_Done=0. Memory contents are not cleared.
- The FSM has two states, LOAD and RUN.
- LOAD:
  - Ld_Ready=1.
  - A transfer occurs on a clock edge with Ld_Valid&Ld_Ready: Mem[ptr]<=Ld_Data, ptr<=ptr+1.
  - The FSM goes to RUN on the same edge if Ld_Last=1 or ptr==LOAD_WORDS-1. If both are true together, there is a single transition and no extra word is written.
  - Data_I=NOP_WORD, Data_D=0 and Fault_I=0 throughout LOAD; En_I and En_D are ignored.
- RUN:
  - Ld_Ready=0 and Load_Done=1. Ld_Valid is ignored and no writes occur.
  - RUN persists until reset.
- Fetch port (RUN):
  - With En_I=1, the edge registers Data_I<=Mem[Addr_I[ADDR_WIDTH-1:0]], giving one-cycle latency.
  - If Addr_I[28:ADDR_WIDTH]!=0, the edge instead registers Data_I<=NOP_WORD and Fault_I<=1.
  - With En_I=0, Data_I and Fault_I hold their values.
- Data port (RUN):
  - With En_D=1, the edge registers Data_D<=Mem[Addr_D[ADDR_WIDTH-1:0]].
  - Out-of-range upper bits return 0; there is no fault flag on the D port.
  - With En_D=0, Data_D holds its value.
- Simultaneous I and D reads, including to the same address, are both serviced in the same cycle.
- The first fetch in RUN returns the word at the address presented on the edge after Load_Done rises. Words not written during the load read as whatever the memory already held.
- Reset during LOAD or RUN aborts immediately. The next load restarts at word 0 and overwrites from the beginning.
- The memory is coded as an inferable simple dual-port RAM: one write port and two synchronous read ports. There are no vendor primitives.

Optional Feature:
Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from Ld_Data on write.
  - Both read ports recompute parity. Parity_Err is registered with the read data and set if either enabled in-range read mismatches.
  - On an I-port mismatch, Data_I<=NOP_WORD.
  - Parity_Err is cleared by the next enabled read with no mismatch and by reset.
- Undefined: no parity storage; Parity_Err is tied to 0.

Test Plan:
- Reset then load 4 words (0x11111111..0x44444444) with Ld_Last on the 4th → Ld_Ready drops and Load_Done=1 the next cycle. Fetching Addr_I=2 yields 0x33333333 one cycle later with Fault_I=0.
- Fetch during LOAD with En_I=1, Addr_I=0 → Data_I=0x83FFF800 and Data_D=0 throughout.
- LOAD_WORDS=4, stream 6 words with Ld_Valid held high and no Ld_Last → exactly 4 accepted. Ld_Ready=0 after the 4th, and Mem[4] is unchanged.
- In RUN, Addr_I=29'h100 with ADDR_WIDTH=8 → Data_I=0x83FFF800 and Fault_I=1. A next fetch at 0 gives Fault_I=0.
- Ld_Valid toggling each cycle while loading → only handshaked words are written, in order, with no gaps in addresses.
- Assert SysReset low mid-load after 2 words, then reload 3 words → Load_Done=0 asynchronously. After the reload, Mem[0..2] hold the new words. With IMEM_PARITY_EN, a forced bit flip on Mem[1] makes a fetch at 1 return NOP and set Parity_Err=1.
